// File: rtl/pixel_scan_gen.sv
// Raster-scan pixel address generator with pacing, optional serpentine order and neighbour flags.
// Define PIXEL_SCAN_CONTINUOUS_EN to make frames repeat back-to-back until abort.
module pixel_scan_gen #(
  parameter int unsigned IMAGEX     = 64,
  parameter int unsigned IMAGEY     = 64,
  parameter int unsigned STEP_DIV   = 1,
  parameter int unsigned SERPENTINE = 0,
  parameter int unsigned X_W        = $clog2(IMAGEX),
  parameter int unsigned Y_W        = $clog2(IMAGEY),
  parameter int unsigned ADDR_W     = $clog2(IMAGEX*IMAGEY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              dir_rtl,
  output logic              last_in_row,
  output logic              last_pixel,
  output logic              nb_fwd,
  output logic              nb_down,
  output logic              nb_down_fwd,
  output logic              nb_down_back,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned RC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [X_W-1:0]  X_MAX  = X_W'(IMAGEX - 1);
  localparam logic [Y_W-1:0]  Y_MAX  = Y_W'(IMAGEY - 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [RC_W-1:0]   rate_cnt;
  logic [X_W-1:0]    adv_x;
  logic [Y_W-1:0]    adv_y;
  logic [ADDR_W-1:0] adv_addr;
  logic              adv_dir;

  // Flags for a position: {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back}.
  function automatic logic [5:0] flags_of(input logic [X_W-1:0] fx,
                                          input logic [Y_W-1:0] fy,
                                          input logic fd);
    logic lir;
    logic back_edge;
    logic down;
    lir       = fd ? (fx == '0) : (fx == X_MAX);
    back_edge = fd ? (fx == X_MAX) : (fx == '0);
    down      = (fy != Y_MAX);
    return {lir, lir && !down, !lir, down, down && !lir, down && !back_edge};
  endfunction

  // Next scan position after a handshake; addr tracks y*IMAGEX+x incrementally.
  always_comb begin
    adv_x    = pix_x;
    adv_y    = pix_y;
    adv_addr = pix_addr;
    adv_dir  = dir_rtl;
    if (!last_in_row) begin
      if (dir_rtl) begin
        adv_x    = pix_x - X_W'(1);
        adv_addr = pix_addr - ADDR_W'(1);
      end else begin
        adv_x    = pix_x + X_W'(1);
        adv_addr = pix_addr + ADDR_W'(1);
      end
    end else if (SERPENTINE != 0) begin
      adv_y    = pix_y + Y_W'(1);
      adv_addr = pix_addr + ADDR_W'(IMAGEX);
      adv_dir  = !dir_rtl;
    end else begin
      adv_x    = '0;
      adv_y    = pix_y + Y_W'(1);
      adv_addr = pix_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rate_cnt   <= '0;
      out_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_addr   <= '0;
      dir_rtl    <= 1'b0;
      {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back} <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      rate_cnt   <= '0;
      out_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_addr   <= '0;
      dir_rtl    <= 1'b0;
      {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back} <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            busy      <= 1'b1;
            rate_cnt  <= '0;
            out_valid <= (RC_MAX == '0);
            pix_x     <= '0;
            pix_y     <= '0;
            pix_addr  <= '0;
            dir_rtl   <= 1'b0;
            {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back} <=
              flags_of('0, '0, 1'b0);
          end
        end
        SCAN: begin
          if (out_valid && out_ready) begin
            rate_cnt <= '0;
            if (last_pixel) begin
              state      <= DONE;
              frame_done <= 1'b1;
              out_valid  <= 1'b0;
              pix_x      <= '0;
              pix_y      <= '0;
              pix_addr   <= '0;
              dir_rtl    <= 1'b0;
              {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back} <= '0;
            end else begin
              out_valid <= (RC_MAX == '0);
              pix_x     <= adv_x;
              pix_y     <= adv_y;
              pix_addr  <= adv_addr;
              dir_rtl   <= adv_dir;
              {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back} <=
                flags_of(adv_x, adv_y, adv_dir);
            end
          end else if (!out_valid) begin
            // Pacing: count toward presentation; a stalled pixel holds the counter.
            rate_cnt  <= rate_cnt + RC_W'(1);
            out_valid <= ((rate_cnt + RC_W'(1)) == RC_MAX);
          end
        end
        DONE: begin
`ifdef PIXEL_SCAN_CONTINUOUS_EN
          state     <= SCAN;
          rate_cnt  <= '0;
          out_valid <= (RC_MAX == '0);
          pix_x     <= '0;
          pix_y     <= '0;
          pix_addr  <= '0;
          dir_rtl   <= 1'b0;
          {last_in_row, last_pixel, nb_fwd, nb_down, nb_down_fwd, nb_down_back} <=
            flags_of('0, '0, 1'b0);
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen on a 4x3 frame: linear, serpentine and paced instances.
module tb_pixel_scan_gen;

  logic clk = 1'b0;
  logic rst, start, abort, ready;

  logic       v0, v1, v2;
  logic [1:0] x0, x1, x2, y0, y1, y2;
  logic [3:0] a0, a1, a2;
  logic dir0, lir0, lp0, fwd0, dn0, df0, db0, busy0, fd0;
  logic dir1, lir1, lp1, fwd1, dn1, df1, db1, busy1, fd1;
  logic dir2, lir2, lp2, fwd2, dn2, df2, db2, busy2, fd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_scan_gen #(.IMAGEX(4), .IMAGEY(3), .STEP_DIV(1), .SERPENTINE(0)) d0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(ready),
    .out_valid(v0), .pix_x(x0), .pix_y(y0), .pix_addr(a0), .dir_rtl(dir0),
    .last_in_row(lir0), .last_pixel(lp0), .nb_fwd(fwd0), .nb_down(dn0),
    .nb_down_fwd(df0), .nb_down_back(db0), .busy(busy0), .frame_done(fd0));

  pixel_scan_gen #(.IMAGEX(4), .IMAGEY(3), .STEP_DIV(1), .SERPENTINE(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(ready),
    .out_valid(v1), .pix_x(x1), .pix_y(y1), .pix_addr(a1), .dir_rtl(dir1),
    .last_in_row(lir1), .last_pixel(lp1), .nb_fwd(fwd1), .nb_down(dn1),
    .nb_down_fwd(df1), .nb_down_back(db1), .busy(busy1), .frame_done(fd1));

  pixel_scan_gen #(.IMAGEX(4), .IMAGEY(3), .STEP_DIV(3), .SERPENTINE(0)) d2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(ready),
    .out_valid(v2), .pix_x(x2), .pix_y(y2), .pix_addr(a2), .dir_rtl(dir2),
    .last_in_row(lir2), .last_pixel(lp2), .nb_fwd(fwd2), .nb_down(dn2),
    .nb_down_fwd(df2), .nb_down_back(db2), .busy(busy2), .frame_done(fd2));

  typedef struct {
    logic rdy;
    int   x, y, addr;
    logic dir, lir, lp, fwd, dn, df, db;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Abort everything, then pulse start; returns at the first SCAN-cycle sample point.
  task automatic restart();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_addr5();
    int n;
    n = 0;
    while (!(v0 && a0 == 4'd5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr5", int'(a0), 5);
  endtask

  initial begin
    int nval, expa, nfd, n;
    logic stall, prevfd;
    logic [3:0] pa;
    logic [1:0] px, py;

    tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0};
    tbl[1]  = '{1, 1, 0, 1,  0, 0, 0, 1, 1, 1, 1};
    tbl[2]  = '{1, 2, 0, 2,  0, 0, 0, 1, 1, 1, 1};
    tbl[3]  = '{1, 3, 0, 3,  0, 1, 0, 0, 1, 0, 1};
    tbl[4]  = '{1, 3, 1, 7,  1, 0, 0, 1, 1, 1, 0};
    tbl[5]  = '{1, 2, 1, 6,  1, 0, 0, 1, 1, 1, 1};
    tbl[6]  = '{1, 1, 1, 5,  1, 0, 0, 1, 1, 1, 1};
    tbl[7]  = '{1, 0, 1, 4,  1, 1, 0, 0, 1, 0, 1};
    tbl[8]  = '{1, 0, 2, 8,  0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 2, 9,  0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{1, 2, 2, 10, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 3, 2, 11, 0, 1, 1, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(v0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_addr", int'(a0), 0);
    chk("rst_nb_down", int'(dn0), 0);
    chk("rst_nb_fwd", int'(fwd1), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy0), 0);

    // Linear order on d0 and serpentine table on d1, ready held high.
    ready = 1'b1;
    restart();
    for (int i = 0; i < 12; i++) begin
      ready = tbl[i].rdy;
      chk($sformatf("lin%0d_valid", i), int'(v0), 1);
      chk($sformatf("lin%0d_addr", i), int'(a0), i);
      chk($sformatf("lin%0d_x", i), int'(x0), i % 4);
      chk($sformatf("lin%0d_y", i), int'(y0), i / 4);
      chk($sformatf("lin%0d_last", i), int'(lp0), (i == 11) ? 1 : 0);
      chk($sformatf("lin%0d_busy", i), int'(busy0), 1);
      chk($sformatf("srp%0d_valid", i), int'(v1), 1);
      chk($sformatf("srp%0d_x", i), int'(x1), tbl[i].x);
      chk($sformatf("srp%0d_y", i), int'(y1), tbl[i].y);
      chk($sformatf("srp%0d_addr", i), int'(a1), tbl[i].addr);
      chk($sformatf("srp%0d_dir", i), int'(dir1), int'(tbl[i].dir));
      chk($sformatf("srp%0d_lir", i), int'(lir1), int'(tbl[i].lir));
      chk($sformatf("srp%0d_lp", i), int'(lp1), int'(tbl[i].lp));
      chk($sformatf("srp%0d_fwd", i), int'(fwd1), int'(tbl[i].fwd));
      chk($sformatf("srp%0d_dn", i), int'(dn1), int'(tbl[i].dn));
      chk($sformatf("srp%0d_df", i), int'(df1), int'(tbl[i].df));
      chk($sformatf("srp%0d_db", i), int'(db1), int'(tbl[i].db));
      chk($sformatf("srp%0d_fd", i), int'(fd1), 0);
      @(negedge clk);
    end
    chk("lin_done_pulse", int'(fd0), 1);
    chk("lin_done_valid", int'(v0), 0);
    chk("srp_done_pulse", int'(fd1), 1);
    @(negedge clk);
    chk("lin_done_single", int'(fd0), 0);
`ifdef PIXEL_SCAN_CONTINUOUS_EN
    chk("lin_cont_busy", int'(busy0), 1);
    chk("lin_cont_addr0", int'(a0), 0);
`else
    chk("lin_idle_busy", int'(busy0), 0);
    chk("srp_idle_busy", int'(busy1), 0);
`endif

    // Paced instance: one valid every third SCAN cycle.
    restart();
    nval = 0;
    for (int i = 0; i < 36; i++) begin
      chk($sformatf("div%0d_valid", i), int'(v2), (i % 3 == 2) ? 1 : 0);
      if (v2) begin
        chk($sformatf("div%0d_addr", i), int'(a2), i / 3);
        nval++;
      end
      @(negedge clk);
    end
    chk("div_count", nval, 12);
    chk("div_done_pulse", int'(fd2), 1);

    // Random backpressure on d0.
    restart();
    expa = 0; stall = 1'b0; pa = '0; px = '0; py = '0; n = 0;
    while (expa < 12 && n < 300) begin
      if (v0) begin
        chk("rnd_addr", int'(a0), expa);
        chk("rnd_xy_addr", int'(a0), int'(y0) * 4 + int'(x0));
        if (stall) begin
          chk("rnd_hold_addr", int'(a0), int'(pa));
          chk("rnd_hold_x", int'(x0), int'(px));
          chk("rnd_hold_y", int'(y0), int'(py));
        end
      end
      ready = 1'($urandom_range(0, 1));
      stall = v0 && !ready;
      pa = a0; px = x0; py = y0;
      if (v0 && ready) expa++;
      @(negedge clk);
      n++;
    end
    chk("rnd_all_pixels", expa, 12);
    chk("rnd_done_pulse", int'(fd0), 1);

    // Abort mid-frame.
    ready = 1'b1;
    restart();
    wait_addr5();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", int'(v0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_addr", int'(a0), 0);
    chk("abort_x", int'(x0), 0);
    chk("abort_nb_down", int'(dn0), 0);
    chk("abort_fd", int'(fd0), 0);
    nfd = 0;
    for (int i = 0; i < 20; i++) begin
      if (fd0 || busy0) nfd++;
      @(negedge clk);
    end
    chk("abort_stays_idle", nfd, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_restart_valid", int'(v0), 1);
    chk("abort_restart_addr", int'(a0), 0);

    // Asynchronous reset mid-frame.
    restart();
    wait_addr5();
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(v0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_addr", int'(a0), 0);
    chk("arst_nb_fwd", int'(fwd0), 0);
    chk("arst_fd", int'(fd0), 0);
    @(negedge clk);
    rst = 1'b0;
    nfd = 0;
    for (int i = 0; i < 20; i++) begin
      if (fd0 || busy0) nfd++;
      @(negedge clk);
    end
    chk("arst_stays_idle", nfd, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("arst_restart_valid", int'(v0), 1);
    chk("arst_restart_addr", int'(a0), 0);

    // Start while busy is ignored: frame keeps advancing.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_ignored", int'(a0), 2);

`ifdef PIXEL_SCAN_CONTINUOUS_EN
    restart();
    nfd = 0; prevfd = 1'b0; nval = 0;
    for (int i = 0; i < 39; i++) begin
      if (!busy0) nval++;
      if (prevfd) begin
        chk("cont_reload_addr", int'(a0), 0);
        chk("cont_reload_valid", int'(v0), 1);
      end
      if (fd0) nfd++;
      prevfd = fd0;
      @(negedge clk);
    end
    chk("cont_busy_drops", nval, 0);
    chk("cont_frames", nfd, 3);
    chk("cont_next_frame_addr", int'(a0), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
